// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Reset duty is half of the full-scale count.
  function automatic logic [31:0] reset_duty(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: active duty register, compare, inversion and output register.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic             invert_i,
  output logic             pwm_o
);

  localparam logic [WIDTH-1:0] DutyRst = WIDTH'(reset_duty(WIDTH));

  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    duty_d = load_i ? duty_i : duty_q;
    pwm_d  = en_i ? ((count_i < duty_q) ^ invert_i) : invert_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      duty_q <= DutyRst;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center-aligned period counter with
// double-buffered period, mode and duty updates applied at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      iCLK,
  input  logic                      iReset,
  input  logic                      iEnable,
  input  logic                      iCenter,
  input  logic [WIDTH-1:0]          iPeriod,
  input  logic [CHANNELS*WIDTH-1:0] iDuty,
  input  logic [CHANNELS-1:0]       iInvert,
  input  logic                      iLoad,
  output logic [CHANNELS-1:0]       oPWM,
  output logic                      oPeriodEnd,
  output logic                      oLoadDone
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  pwm_mode_e        center_q, center_d;
  logic             down_q, down_d;
  logic             pending_q, pending_d;
  logic             period_end_q, period_end_d;
  logic             load_done_q, load_done_d;

  logic at_top, terminal, load_req, apply;

  always_comb begin
    at_top   = (cnt_q == period_q);
    // In center mode the peak also ends the period when P==1 (sequence 0,1).
    if (period_q == '0)
      terminal = 1'b1;
    else if (center_q == PWM_EDGE)
      terminal = at_top;
    else
      terminal = (cnt_q == One) && (down_q || at_top);

    load_req = pending_q | iLoad;
    apply    = load_req && (!iEnable || terminal);

    cnt_d  = cnt_q;
    down_d = down_q;
    if (!iEnable || terminal) begin
      cnt_d  = '0;
      down_d = 1'b0;
    end else if (center_q == PWM_CENTER) begin
      cnt_d  = (down_q || at_top) ? cnt_q - One : cnt_q + One;
      down_d = down_q | at_top;
    end else begin
      cnt_d = cnt_q + One;
    end

    pending_d    = apply ? 1'b0 : load_req;
    period_d     = apply ? iPeriod : period_q;
    center_d     = apply ? pwm_mode_e'(iCenter) : center_q;
    period_end_d = iEnable && terminal;
    load_done_d  = apply;
  end

  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) begin
      cnt_q        <= '0;
      period_q     <= '1;
      center_q     <= PWM_EDGE;
      down_q       <= 1'b0;
      pending_q    <= 1'b0;
      period_end_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      center_q     <= center_d;
      down_q       <= down_d;
      pending_q    <= pending_d;
      period_end_q <= period_end_d;
      load_done_q  <= load_done_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i   (iCLK),
      .rst_i   (iReset),
      .en_i    (iEnable),
      .load_i  (apply),
      .count_i (cnt_q),
      .duty_i  (iDuty[c*WIDTH +: WIDTH]),
      .invert_i(iInvert[c]),
      .pwm_o   (oPWM[c])
    );
  end

  assign oPeriodEnd = period_end_q;
  assign oLoadDone  = load_done_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed table, hand sequences and randomized run against a phase-based model.
module tb_pwm_multi;

  localparam int unsigned W = 12;
  localparam int unsigned C = 4;

  logic             clk = 1'b0;
  logic             rst, en, center, load;
  logic [W-1:0]     period;
  logic [C*W-1:0]   duty;
  logic [C-1:0]     inv;
  logic [C-1:0]     pwm;
  logic             pe, ld;

  always #5 clk = ~clk;

  pwm_multi #(
    .WIDTH   (W),
    .CHANNELS(C)
  ) dut (
    .iCLK      (clk),
    .iReset    (rst),
    .iEnable   (en),
    .iCenter   (center),
    .iPeriod   (period),
    .iDuty     (duty),
    .iInvert   (inv),
    .iLoad     (load),
    .oPWM      (pwm),
    .oPeriodEnd(pe),
    .oLoadDone (ld)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: position within the period, count derived arithmetically.
  int       m_per, m_center, m_phase, m_pend;
  int       m_duty[C];
  logic [C-1:0] e_pwm;
  logic     e_pe, e_ld;

  function automatic int mlen();
    if (m_per == 0) return 1;
    return (m_center != 0) ? 2 * m_per : m_per + 1;
  endfunction

  function automatic int mcount();
    if (m_per == 0) return 0;
    if (m_center == 0) return m_phase;
    return (m_phase <= m_per) ? m_phase : 2 * m_per - m_phase;
  endfunction

  task automatic model_reset();
    m_per = 4095; m_center = 0; m_phase = 0; m_pend = 0;
    for (int c = 0; c < C; c++) m_duty[c] = 2048;
    e_pwm = '0; e_pe = 1'b0; e_ld = 1'b0;
  endtask

  task automatic model_step();
    int  cnt;
    bit  term, req;
    cnt  = mcount();
    term = (m_phase == mlen() - 1);
    req  = (m_pend != 0) || load;
    for (int c = 0; c < C; c++)
      e_pwm[c] = en ? ((cnt < m_duty[c]) ^ inv[c]) : inv[c];
    e_pe = en && term;
    if (req && (!en || term)) begin
      m_per    = int'(period);
      m_center = int'(center);
      for (int c = 0; c < C; c++) m_duty[c] = int'(duty[c*W +: W]);
      m_pend   = 0;
      e_ld     = 1'b1;
    end else begin
      e_ld   = 1'b0;
      m_pend = req ? 1 : 0;
    end
    m_phase = (!en || term) ? 0 : m_phase + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pwm", 32'(pwm), 32'(e_pwm));
    check("period_end", 32'(pe), 32'(e_pe));
    check("load_done", 32'(ld), 32'(e_ld));
  endtask

  int hic[C];
  int pec, ldc, both;

  task automatic clear_acc();
    for (int c = 0; c < C; c++) hic[c] = 0;
    pec = 0; ldc = 0; both = 0;
  endtask

  task automatic tick_acc();
    tick();
    for (int c = 0; c < C; c++) hic[c] += int'(pwm[c]);
    pec  += int'(pe);
    ldc  += int'(ld);
    both += int'(pe & ld);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_period_end", 32'(pe), 32'd0);
    check("reset_load_done", 32'(ld), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [W-1:0] p, input logic [C*W-1:0] d, input logic cn, input logic [C-1:0] iv);
    en = 1'b0;
    tick();
    period = p; duty = d; center = cn; inv = iv; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    en = 1'b1;
  endtask

  function automatic logic [C*W-1:0] all_duty(input int d);
    logic [C*W-1:0] r;
    for (int c = 0; c < C; c++) r[c*W +: W] = W'(d);
    return r;
  endfunction

  typedef struct {
    logic [W-1:0]           per;
    logic [C-1:0][W-1:0]    d;
    logic                   cen;
    logic [C-1:0]           iv;
    int                     n;
    logic [C-1:0][15:0]     hi;
    int                     npe;
  } vec_t;

  localparam int NV = 7;
  vec_t vec[NV];

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int last_pe;
    logic [7:0] pat;

    vec[0] = '{per:12'd9, d:{12'd10, 12'd9, 12'd3, 12'd0}, cen:1'b0, iv:4'b0000, n:20,
               hi:{16'd20, 16'd18, 16'd6, 16'd0}, npe:2};
    vec[1] = '{per:12'd9, d:{12'd10, 12'd9, 12'd3, 12'd0}, cen:1'b0, iv:4'b1010, n:20,
               hi:{16'd0, 16'd18, 16'd14, 16'd0}, npe:2};
    vec[2] = '{per:12'd4, d:{12'd5, 12'd4, 12'd0, 12'd2}, cen:1'b1, iv:4'b0000, n:16,
               hi:{16'd16, 16'd14, 16'd0, 16'd6}, npe:2};
    vec[3] = '{per:12'd4, d:{12'd5, 12'd4, 12'd0, 12'd2}, cen:1'b1, iv:4'b0001, n:16,
               hi:{16'd16, 16'd14, 16'd0, 16'd10}, npe:2};
    vec[4] = '{per:12'd0, d:{12'd0, 12'd5, 12'd1, 12'd0}, cen:1'b0, iv:4'b0000, n:4,
               hi:{16'd0, 16'd4, 16'd4, 16'd0}, npe:4};
    vec[5] = '{per:12'd1, d:{12'd1, 12'd0, 12'd2, 12'd1}, cen:1'b1, iv:4'b0000, n:4,
               hi:{16'd2, 16'd0, 16'd4, 16'd2}, npe:2};
    vec[6] = '{per:12'd5, d:{12'd1, 12'd4095, 12'd6, 12'd5}, cen:1'b0, iv:4'b0000, n:12,
               hi:{16'd2, 16'd12, 16'd12, 16'd10}, npe:2};

    en = 1'b1; center = 1'b0; load = 1'b0; period = '0; duty = '0; inv = '0;
    apply_reset();

    // Reset defaults: P=4095, D=2048 on every channel.
    clear_acc();
    last_pe = -1;
    for (int i = 1; i <= 8192; i++) begin
      tick_acc();
      if (pe) begin
        if (last_pe >= 0) check("default_pe_gap", 32'(i - last_pe), 32'd4096);
        last_pe = i;
      end
    end
    for (int c = 0; c < C; c++) check("default_high", 32'(hic[c]), 32'd4096);
    check("default_pe_count", 32'(pec), 32'd2);

    for (int v = 0; v < NV; v++) begin
      cfg(vec[v].per, vec[v].d, vec[v].cen, vec[v].iv);
      clear_acc();
      repeat (vec[v].n) tick_acc();
      for (int c = 0; c < C; c++) check("table_high", 32'(hic[c]), 32'(vec[v].hi[c]));
      check("table_pe_count", 32'(pec), 32'(vec[v].npe));
    end

    // Center P=4, D=2: high at counts 0,1 then 1 on the way down.
    cfg(12'd4, all_duty(2), 1'b1, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[i] = pwm[0];
    end
    check("center_pattern", 32'(pat), 32'b1000_0011);

    // Mid-period duty update 3 -> 7 at count 4.
    cfg(12'd9, all_duty(3), 1'b0, 4'b0000);
    clear_acc();
    for (int k = 0; k < 20; k++) begin
      if (k == 4) begin duty = all_duty(7); load = 1'b1; end
      tick_acc();
      load = 1'b0;
    end
    check("midupd_high", 32'(hic[0]), 32'd10);
    check("midupd_load_done", 32'(ldc), 32'd1);
    check("midupd_ld_with_pe", 32'(both), 32'd1);

    // Repeated loads while pending, last one coincident with the terminal cycle.
    cfg(12'd9, all_duty(3), 1'b0, 4'b0000);
    clear_acc();
    for (int k = 0; k < 20; k++) begin
      if (k == 2) begin duty = all_duty(5); load = 1'b1; end
      if (k == 5) begin duty = all_duty(6); load = 1'b1; end
      if (k == 9) begin duty = all_duty(8); load = 1'b1; end
      tick_acc();
      load = 1'b0;
    end
    check("coinc_high0", 32'(hic[0]), 32'd11);
    check("coinc_high3", 32'(hic[3]), 32'd11);
    check("coinc_load_done", 32'(ldc), 32'd1);

    // Reset while a load is pending and outputs are high.
    cfg(12'd9, all_duty(3), 1'b0, 4'b1111);
    repeat (3) tick();
    duty = all_duty(7); load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    check("pre_reset_pwm", 32'(pwm), 32'hF);
    #3;
    inv = '0;
    apply_reset();
    clear_acc();
    repeat (4096) tick_acc();
    for (int c = 0; c < C; c++) check("post_reset_high", 32'(hic[c]), 32'd2048);
    check("post_reset_load_done", 32'(ldc), 32'd0);
    check("post_reset_pe", 32'(pec), 32'd1);

    // Randomized traffic against the model.
    cfg(12'd6, all_duty(3), 1'b1, 4'b0000);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) en = ~en;
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        period = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 12));
        for (int c = 0; c < C; c++) duty[c*W +: W] = W'($urandom_range(0, 14));
        center = 1'($urandom_range(0, 1));
        inv    = C'($urandom_range(0, 15));
      end
      tick();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator, next generation of the single-channel 12-bit PWM in the Zynq lab IP. One shared period counter drives `CHANNELS` independent compare outputs. It supports a programmable period, edge- or center-aligned counting, per-channel output inversion, and glitch-free double-buffered updates applied only at period boundaries. It sits behind the AXI register slave of the `myPWM` IP; all inputs come from held software registers.

## Interface
- `WIDTH`, 12: counter, period and duty width.
- `CHANNELS`, 4: number of PWM outputs (≥1).

- `iCLK`, input, 1: sole clock, rising edge.
- `iReset`, input, 1: asynchronous, active-high reset.
- `iEnable`, input, 1: run counter; low holds the block idle.
- `iCenter`, input, 1: mode request; 0 = edge-aligned, 1 = center-aligned (shadowed).
- `iPeriod`, input, WIDTH: period value P (shadowed).
- `iDuty`, input, CHANNELS*WIDTH: duty D[c] at bits [c*WIDTH +: WIDTH] (shadowed).
- `iInvert`, input, CHANNELS: per-channel output inversion (not shadowed).
- `iLoad`, input, 1: single-cycle request to transfer the shadow inputs at the next boundary.
- `oPWM`, output, CHANNELS: registered PWM outputs.
- `oPeriodEnd`, output, 1: one-cycle pulse at each period start.
- `oLoadDone`, output, 1: one-cycle pulse when shadow values take effect.

## Operation
- Active registers: `rPeriod`, `rDuty[c]`, `rCenter`. Inputs never affect the outputs directly, except `iInvert`.
- **Edge mode**: count runs 0,1,…,P, then wraps to 0. Period is P+1 cycles.
- **Center mode**: count runs 0 up to P, then down to 1, then 0. Period is 2P cycles. Direction flag `rDown` is set at count==P and cleared at count==1.
- **P==0 (either mode)**: count holds at 0; every cycle is terminal.
- **Terminal cycle**: the last cycle before the count returns to 0.
- **Compare**: the channel is active while count < D[c].
  - D==0 gives constant inactive.
  - D > P gives constant active.
  - Output is `oPWM[c] = active ^ iInvert[c]`, registered.
- **Load**:
  - `iLoad` sets `rPending`; further `iLoad` pulses while pending are absorbed.
  - In a terminal cycle with `rPending` (or `iLoad`) set, the block captures `iPeriod`, `iDuty` and `iCenter` as sampled in that cycle. It then clears `rPending`, resets `rDown`, and pulses `oLoadDone` in the next cycle.
- **Disable** (`iEnable`=0):
  - Count forced to 0 and `rDown` to 0.
  - `oPWM` = `iInvert` (idle inactive).
  - `oPeriodEnd` = 0.
  - Any `iLoad`, or a pending load, is applied every cycle, so configuration made while stopped takes effect immediately.
- **Enable rising**: the first enabled cycle has count 0 and is not flagged by `oPeriodEnd`.

## Timing
- Reset values:
  - count = 0, `rDown` = 0, `rPending` = 0.
  - `rPeriod` = all ones, `rDuty[c]` = 1<<(WIDTH-1), `rCenter` = 0.
  - `oPWM` = 0, `oPeriodEnd` = 0, `oLoadDone` = 0.
- Output latency: `oPWM` reflects the count of the previous cycle, a fixed 1-cycle lag.
- `oPeriodEnd` is asserted in the cycle the count equals 0 after a terminal cycle. It coincides with the first `oPWM` of the new period.
- A load in terminal cycle T has these effects:
  - New values are active from T+1.
  - New `oPWM` levels appear from T+2.
  - `oLoadDone` is high in T+1.
- Simultaneous `iLoad` and terminal cycle: the load is applied at that boundary.
- A mode change only takes effect at a boundary, so there is never a partial triangle.
- Reset mid-period: all state returns to reset values asynchronously, and any pending load is discarded.
- Widths: all compares are unsigned WIDTH-bit. The count never exceeds P, so no overflow occurs.

## Structure
- Package `pwm_pkg`:
  - mode constants `PWM_EDGE`=0 and `PWM_CENTER`=1.
  - reset-duty constant function of WIDTH.
- Sub-module `pwm_channel`: holds `rDuty`, the compare, the inversion and the `oPWM` register. It takes count, load strobe and enable as inputs and is instantiated CHANNELS times in a generate loop.
- The top level owns the counter, direction, pending and pulse logic.

## Test plan
- **Reset defaults**, WIDTH=12: release reset with enable=1 and no load → each `oPWM` is high for 2048 of every 4096 cycles, and `oPeriodEnd` fires every 4096 cycles.
- **Edge mode**, WIDTH=8, P=9, D={0,3,9,10}, load while disabled, then enable → per 10-cycle period, high counts are 0, 3, 9 and 10. `oPeriodEnd` fires every 10 cycles.
- **Center mode**, P=4, D[0]=2 → count sequence 0,1,2,3,4,3,2,1. `oPWM[0]` is high for 3 of 8 cycles, centered on count 0. `iInvert[0]`=1 gives the complement.
- **Mid-period update**: pulse `iLoad` with D=7 at count 4 of P=9/D=3 → the current period keeps 3 high cycles. `oLoadDone` pulses with the next `oPeriodEnd`, and the following period has 7 high cycles.
- **Load coincident with terminal cycle**, plus a second `iLoad` while pending → exactly one `oLoadDone`, and the values sampled at the terminal cycle are used.
- **Reset mid-period**: assert `iReset` with a load pending → `oPWM` goes to 0 immediately, and the defaults from the first scenario resume with no `oLoadDone`.
